// File: rtl/sram_port_arbiter.sv
// Shares the single-port management SRAM between the CPU port (read/write, priority)
// and the read-only housekeeping port, with a bounded-wait counter for housekeeping.
module sram_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            core_clk,
  input  logic            core_rstn,
  input  logic            cpu_ena,
  input  logic [DW/8-1:0] cpu_wen,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_ready,
  input  logic            ro_req,
  input  logic [AW-1:0]   ro_addr,
  output logic [DW-1:0]   ro_data,
  output logic            ro_ack,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_CPU,
    RESP_CPU,
    ISSUE_HK,
    RESP_HK,
    DONE_HK
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          arb_point;
  logic          hk_busy;
  logic          hk_elig;
  logic          grant_hk;
  logic          grant_cpu;

  // ro_req is still held during the ack cycle, so it is masked in DONE_HK.
  always_comb begin
    arb_point = (state == IDLE) || (state == RESP_CPU) || (state == DONE_HK);
    hk_busy   = (state == ISSUE_HK) || (state == RESP_HK) || (state == DONE_HK);
    hk_elig   = ro_req && (state != DONE_HK);
    grant_hk  = arb_point && hk_elig && ((wait_cnt >= LIMIT) || !cpu_ena);
    grant_cpu = arb_point && !grant_hk && cpu_ena;
  end

  assign cpu_rdata = ram_do;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_di    <= '0;
      cpu_ready <= 1'b0;
      ro_ack    <= 1'b0;
      ro_data   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      ro_ack    <= 1'b0;
      ram_en    <= 1'b0;

      if (grant_hk) begin
        wait_cnt <= '0;
      end else if (ro_req && !hk_busy && (wait_cnt < LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        ISSUE_CPU: begin
          state     <= RESP_CPU;
          cpu_ready <= 1'b1;
        end
        ISSUE_HK: begin
          state <= RESP_HK;
        end
        RESP_HK: begin
          state   <= DONE_HK;
          ro_data <= ram_do;
          ro_ack  <= 1'b1;
        end
        default: begin
          if (grant_hk) begin
            state    <= ISSUE_HK;
            ram_en   <= 1'b1;
            ram_we   <= '0;
            ram_addr <= ro_addr;
          end else if (grant_cpu) begin
            state    <= ISSUE_CPU;
            ram_en   <= 1'b1;
            ram_we   <= cpu_wen;
            ram_addr <= cpu_addr;
            ram_di   <= cpu_wdata;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a transaction-schedule model plus a RAM
// model, compared against the DUT every cycle, with directed and random traffic.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int LIM = 4;
  localparam int DEPTH = 2 ** AW;

  logic          core_clk = 1'b0;
  logic          core_rstn;
  logic          cpu_ena;
  logic [NB-1:0] cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          ro_req;
  logic [AW-1:0] ro_addr;
  logic [DW-1:0] ro_data;
  logic          ro_ack;
  logic          ram_en;
  logic [NB-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .cpu_ena   (cpu_ena),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ro_req    (ro_req),
    .ro_addr   (ro_addr),
    .ro_data   (ro_data),
    .ro_ack    (ro_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  always #5 core_clk = ~core_clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Physical RAM driven by the DUT, and the reference contents the model expects.
  logic [DW-1:0] bench_mem [DEPTH];
  logic [DW-1:0] ref_mem   [DEPTH];

  // Schedule model: each grant at edge g reserves the port until free_at.
  int            n;
  int            free_at;
  int            cpu_grant;
  int            hk_grant;
  int            wait_m;
  bit            pend_v;
  logic [AW-1:0] pend_a;
  logic [NB-1:0] pend_we;
  logic [DW-1:0] pend_d;
  logic          exp_ram_en;
  logic [NB-1:0] exp_ram_we;
  logic [AW-1:0] exp_ram_addr;
  logic [DW-1:0] exp_ram_di;
  logic          exp_cpu_ready;
  logic          exp_ro_ack;
  logic [DW-1:0] exp_ro_data;
  logic          exp_read;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] hk_data;
  bit            arb;
  bit            elig;
  bit            in_hk;
  bit            g_hk;
  bit            g_cpu;

  function automatic void model_reset();
    free_at       = 0;
    cpu_grant     = -100;
    hk_grant      = -100;
    wait_m        = 0;
    pend_v        = 1'b0;
    exp_ram_en    = 1'b0;
    exp_ram_we    = '0;
    exp_ram_addr  = '0;
    exp_ram_di    = '0;
    exp_cpu_ready = 1'b0;
    exp_ro_ack    = 1'b0;
    exp_ro_data   = '0;
    exp_read      = 1'b0;
  endfunction

  function automatic void model_step();
    n++;
    if (pend_v) begin
      for (int b = 0; b < NB; b++)
        if (pend_we[b]) ref_mem[pend_a][b*8 +: 8] = pend_d[b*8 +: 8];
      pend_v = 1'b0;
    end
    exp_cpu_ready = (n == cpu_grant + 1);
    exp_ro_ack    = (n == hk_grant + 2);
    if (n == hk_grant + 2) exp_ro_data = hk_data;
    in_hk = (n >= hk_grant + 1) && (n <= hk_grant + 3);
    arb   = (n >= free_at);
    elig  = ro_req && (n != hk_grant + 3);
    g_hk  = arb && elig && ((wait_m >= LIM) || !cpu_ena);
    g_cpu = arb && !g_hk && cpu_ena;
    exp_ram_en = g_hk || g_cpu;
    if (g_hk) begin
      exp_ram_we   = '0;
      exp_ram_addr = ro_addr;
      hk_data      = ref_mem[ro_addr];
      hk_grant     = n;
      free_at      = n + 3;
      wait_m       = 0;
    end else begin
      if (ro_req && !in_hk && wait_m < LIM) wait_m++;
      if (g_cpu) begin
        exp_ram_we   = cpu_wen;
        exp_ram_addr = cpu_addr;
        exp_ram_di   = cpu_wdata;
        exp_read     = (cpu_wen == '0);
        exp_rdata    = ref_mem[cpu_addr];
        cpu_grant    = n;
        free_at      = n + 2;
        if (cpu_wen != '0) begin
          pend_v  = 1'b1;
          pend_a  = cpu_addr;
          pend_we = cpu_wen;
          pend_d  = cpu_wdata;
        end
      end
    end
  endfunction

  initial begin
    n      = 0;
    ram_do = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bench_mem[i] = $urandom;
      ref_mem[i]   = bench_mem[i];
    end
    model_reset();
    forever begin
      @(posedge core_clk or negedge core_rstn);
      if (!core_rstn) begin
        model_reset();
      end else begin
        if (ram_en) begin
          ram_do <= bench_mem[ram_addr];
          for (int b = 0; b < NB; b++)
            if (ram_we[b]) bench_mem[ram_addr][b*8 +: 8] = ram_di[b*8 +: 8];
        end
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge core_clk);
      check("ram_en", ram_en, exp_ram_en);
      check("ram_we", ram_we, exp_ram_we);
      check("ram_addr", ram_addr, exp_ram_addr);
      check("ram_di", ram_di, exp_ram_di);
      check("cpu_ready", cpu_ready, exp_cpu_ready);
      check("ro_ack", ro_ack, exp_ro_ack);
      check("ro_data", ro_data, exp_ro_data);
      if (exp_cpu_ready && exp_read) check("cpu_rdata", cpu_rdata, exp_rdata);
    end
  end

  // All stimulus tasks are entered just after a rising edge.
  task automatic cpu_access(input logic [AW-1:0] a, input logic [NB-1:0] we,
                            input logic [DW-1:0] d, output logic [DW-1:0] rd,
                            output int edges);
    bit done = 1'b0;
    cpu_ena = 1'b1; cpu_addr = a; cpu_wen = we; cpu_wdata = d;
    edges = 0; rd = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge core_clk); #1;
      edges++;
      if (cpu_ready) begin
        rd   = cpu_rdata;
        done = 1'b1;
      end
    end
    check("cpu_done", {31'd0, done}, 32'd1);
  endtask

  task automatic hk_read(input logic [AW-1:0] a, output logic [DW-1:0] rd, output int edges);
    bit done = 1'b0;
    ro_req = 1'b1; ro_addr = a;
    edges = 0; rd = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge core_clk); #1;
      edges++;
      if (ro_ack) begin
        rd   = ro_data;
        done = 1'b1;
      end
    end
    check("hk_done", {31'd0, done}, 32'd1);
    @(posedge core_clk); #1;
    ro_req = 1'b0;
  endtask

  task automatic cpu_random_master(input int count);
    logic [DW-1:0] rd;
    int e;
    for (int t = 0; t < count; t++) begin
      cpu_access(AW'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0, $urandom, rd, e);
      if ($urandom_range(0, 2) == 0) begin
        cpu_ena = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge core_clk);
        #1;
      end
    end
    cpu_ena = 1'b0;
  endtask

  task automatic hk_random_master(input int count);
    logic [DW-1:0] rd;
    int e;
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 6)) @(posedge core_clk);
      #1;
      hk_read(AW'($urandom_range(0, 15)), rd, e);
    end
  endtask

  task automatic reset_storm(input int count);
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(20, 60)) @(posedge core_clk);
      #3 core_rstn = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge core_clk);
      #3 core_rstn = 1'b1;
    end
  endtask

  int  cpu_before;
  bit  hk_fin;

  initial begin
    logic [DW-1:0] rd;
    int e;
    cpu_ena = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    ro_req = 1'b0; ro_addr = '0; core_rstn = 1'b0;
    repeat (3) @(posedge core_clk);
    #1;
    check("reset_ram_en", {31'd0, ram_en}, 32'd0);
    check("reset_ro_data", ro_data, 32'd0);
    #2 core_rstn = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;

    cpu_access(8'h10, 4'hF, 32'hDEADBEEF, rd, e);
    check("write_latency", e, 32'd2);
    cpu_access(8'h10, 4'h0, 32'h0, rd, e);
    check("read_latency", e, 32'd2);
    check("read_data", rd, 32'hDEADBEEF);
    cpu_access(8'h10, 4'b0010, 32'h0000AA00, rd, e);
    cpu_ena = 1'b0;
    repeat (2) @(posedge core_clk);
    #1;

    ro_req = 1'b1; ro_addr = 8'h10;
    @(posedge core_clk); #1;
    check("hk_issue_en", {31'd0, ram_en}, 32'd1);
    check("hk_issue_we", {28'd0, ram_we}, 32'd0);
    @(posedge core_clk); #1;
    check("hk_resp_noack", {31'd0, ro_ack}, 32'd0);
    @(posedge core_clk); #1;
    check("hk_ack", {31'd0, ro_ack}, 32'd1);
    check("hk_data", ro_data, 32'hDEADAAEF);
    @(posedge core_clk); #1;
    ro_req = 1'b0;
    check("hk_ack_width", {31'd0, ro_ack}, 32'd0);
    repeat (3) @(posedge core_clk);
    #1;
    check("hk_data_hold", ro_data, 32'hDEADAAEF);

    cpu_access(8'h10, 4'h0, 32'h0, rd, e);
    check("byte_merge", rd, 32'hDEADAAEF);
    cpu_ena = 1'b0;
    repeat (2) @(posedge core_clk);
    #1;

    // Continuous CPU traffic against one housekeeping read.
    cpu_before = 0;
    hk_fin     = 1'b0;
    fork
      begin
        logic [DW-1:0] crd;
        int ce;
        while (!hk_fin) begin
          cpu_access(AW'($urandom_range(32, 63)), 4'h0, 32'h0, crd, ce);
          if (!hk_fin) cpu_before++;
        end
        cpu_ena = 1'b0;
      end
      begin
        logic [DW-1:0] hrd;
        int he;
        hk_read(8'h10, hrd, he);
        check("starve_ack_edges", he, 32'd7);
        check("starve_data", hrd, 32'hDEADAAEF);
        hk_fin = 1'b1;
      end
    join
    check("starve_cpu_first", cpu_before, 32'd2);
    repeat (3) @(posedge core_clk);
    #1;

    // Reset while the housekeeping read sits in its response cycle.
    ro_req = 1'b1; ro_addr = 8'h10;
    @(posedge core_clk); #1;
    check("rst_hk_issue", {31'd0, ram_en}, 32'd1);
    @(posedge core_clk); #3;
    core_rstn = 1'b0;
    #1;
    check("rst_async_ack", {31'd0, ro_ack}, 32'd0);
    check("rst_async_data", ro_data, 32'd0);
    check("rst_async_ram_en", {31'd0, ram_en}, 32'd0);
    @(posedge core_clk); #3;
    core_rstn = 1'b1;
    @(posedge core_clk); #1;
    hk_read(8'h10, rd, e);
    check("rst_hk_reserve", rd, 32'hDEADAAEF);
    repeat (2) @(posedge core_clk);
    #1;

    fork
      cpu_random_master(150);
      hk_random_master(40);
      reset_storm(3);
    join
    repeat (5) @(posedge core_clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the single-port management SRAM (DFFRAM) between the CPU memory interface and the housekeeping read-only port. The CPU port is read/write and the housekeeping port is read-only. The block sits between `mgmt_core`'s `mem_*` interface, the housekeeping `sram_ro_*` access path, and the DFFRAM macro. The CPU has priority, and a bounded-wait counter guarantees housekeeping forward progress. Housekeeping requests arrive already synchronized to `core_clk`.

## Interface
Parameters:
- `AW`, 8, word address width.
- `DW`, 32, data width. Byte-write granularity is DW/8 lanes.
- `STARVE_LIMIT`, 4, number of pending edges after which housekeeping wins the next arbitration. Must be ≥1. Counter width is clog2(STARVE_LIMIT+1).

Ports:
- `core_clk`  in  1  sole clock. All state updates on the rising edge.
- `core_rstn`  in  1  reset, asynchronous, active-low.
- `cpu_ena`  in  1  CPU request. Held with its fields until `cpu_ready`.
- `cpu_wen`  in  DW/8  byte write enables. All-zero means read.
- `cpu_addr`  in  AW  CPU word address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  combinational pass-through of `ram_do`.
- `cpu_ready`  out  1  one-cycle completion strobe, registered.
- `ro_req`  in  1  housekeeping read request. Held with `ro_addr` until `ro_ack`.
- `ro_addr`  in  AW  housekeeping word address.
- `ro_data`  out  DW  registered read data. Held until the next housekeeping completion.
- `ro_ack`  out  1  one-cycle completion strobe, registered.
- `ram_en`  out  1  RAM enable, registered.
- `ram_we`  out  DW/8  RAM byte write enables, registered.
- `ram_addr`  out  AW  RAM address, registered.
- `ram_di`  out  DW  RAM write data, registered.
- `ram_do`  in  DW  RAM read data, valid in the cycle after the edge that samples `ram_en`=1.

## Operation
States:
- IDLE
- ISSUE_CPU
- RESP_CPU
- ISSUE_HK
- RESP_HK
- DONE_HK

Arbitration points:
- Arbitration happens only at edges leaving IDLE, RESP_CPU or DONE_HK.
- In DONE_HK, `ro_req` is masked, because the requester still holds it during the ack cycle.
- In RESP_CPU, `cpu_ena` at the edge is treated as a new request (standard held-until-ack semantics).

Grant rule at an arbitration point:
- If hk eligible and `wait_cnt` ≥ STARVE_LIMIT: grant HK.
- Otherwise, if `cpu_ena`: grant CPU.
- Otherwise, if hk eligible: grant HK.
- Otherwise: go to IDLE.

CPU grant:
- Load `ram_en`=1, `ram_we`=`cpu_wen`, `ram_addr`=`cpu_addr`, `ram_di`=`cpu_wdata`.
- Go to ISSUE_CPU, then RESP_CPU unconditionally.
- In RESP_CPU: `ram_en`=0 and `cpu_ready`=1.
- For writes, `cpu_rdata` is don't-care.

HK grant:
- Load `ram_en`=1, `ram_we`=0, `ram_addr`=`ro_addr`.
- Go to ISSUE_HK, then RESP_HK.
- At the edge leaving RESP_HK, `ro_data` <= `ram_do`, then go to DONE_HK.
- In DONE_HK: `ro_ack`=1.

Housekeeping can never write the RAM: `ram_we` is forced to 0 on every HK grant.

Wait counter (`wait_cnt`):
- Increments, saturating at STARVE_LIMIT, on every edge where `ro_req`=1 and the state is not ISSUE_HK, RESP_HK or DONE_HK and no HK grant occurs.
- Cleared on HK grant.

`ram_en` is high only during ISSUE_* cycles. `ram_we`, `ram_addr` and `ram_di` hold their values until the next grant.

Reset, asserted at any time, including mid-access:
- State returns to IDLE immediately.
- `ram_en`, `ram_we`, `ram_addr`, `ram_di`, `cpu_ready`, `ro_ack`, `ro_data` and `wait_cnt` all return to 0.
- The aborted access produces no strobe.

## Timing
- Request seen at arbitration edge E0: ISSUE occupies cycle E0→E1, and the RAM executes at E1.
- CPU latency: `cpu_ready` is high in cycle E1→E2, with `cpu_rdata`=`ram_do`. Back-to-back CPU accesses issue every 2 cycles.
- HK latency: `ro_data` is updated at E2, and `ro_ack` is high in cycle E2→E3.
- Simultaneous requests with `wait_cnt` < STARVE_LIMIT: CPU is served first.
- Worst-case HK wait under continuous CPU traffic: STARVE_LIMIT edges of pending before the grant.
- Strobes are exactly one cycle wide. Requests are never dropped while held.

## Test plan
- Reset: assert `core_rstn`=0 mid-run → all outputs 0 within the same cycle (asynchronous). Release → IDLE, no strobes until a request arrives.
- CPU write then read:
  - Write: `cpu_wen`=4'hF, addr 8'h10, data 32'hDEADBEEF → `ram_en` 1 cycle, `cpu_ready` 2 cycles after the sampling edge.
  - Read: same address → `cpu_rdata`=32'hDEADBEEF while `cpu_ready`=1.
- Byte write: `cpu_wen`=4'b0010, data 32'h0000AA00 to addr 8'h10 → subsequent read returns 32'hDEADAAEF.
- HK read of addr 8'h10 → `ram_we`=0 during issue, `ro_ack` 3 cycles after the sampling edge, `ro_data`=32'hDEADAAEF held after `ro_ack` drops.
- Contention, STARVE_LIMIT=4, `cpu_ena` held high continuously with `ro_req` raised:
  - First arbitration goes to CPU.
  - HK is granted at the first arbitration point after `wait_cnt` reaches 4.
  - `wait_cnt` then returns to 0 and the CPU resumes.
- Reset asserted during RESP_HK → no `ro_ack`, `ro_data`=0. After release, the still-held `ro_req` is served normally.
